// File: rtl/bof_range_monitor.sv
// Buffer-overflow range monitor: tracks runs of contiguous non-frame stores, commits long runs
// and flags loads that land in them. Define BOF_RANGE_CRASH_EN to enable the crash request.
module bof_range_monitor #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned AW      = 32,
  parameter int unsigned MIN_RUN = 32,
  parameter int unsigned TIMEOUT = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   valid_i,
  input  logic [1:0]             op_i,
  input  logic [AW-1:0]          addr_i,
  input  logic [2:0]             size_i,
  input  logic                   frame_i,
  output logic                   hit_o,
  output logic                   crash_o,
  output logic                   active_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned RunW = AW + 1;
  localparam logic [7:0]      TimerInit = 8'(TIMEOUT);
  localparam logic [RunW-1:0] MinRun    = RunW'(MIN_RUN);
  localparam logic [CntW-1:0] CntMax    = CntW'(DEPTH);

  typedef enum logic [0:0] {StIdle, StTrack} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   run_start_q, run_start_d;
  logic [AW-1:0]   run_end_q, run_end_d;
  logic [RunW-1:0] run_len_q, run_len_d;
  logic [7:0]      timer_q, timer_d;

  logic [AW-1:0]    ent_start_q [DEPTH];
  logic [AW-1:0]    ent_end_q   [DEPTH];
  logic [DEPTH-1:0] ent_vld_q;
  logic [PtrW-1:0]  wr_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             hit_q;

  logic            store_v, load_v, wrapped, ext_wrap, commit_ok, commit, match;
  logic [RunW-1:0] ext_sum;
  logic [AW-1:0]   open_end;

  assign store_v   = valid_i && (op_i == 2'd1) && !frame_i;
  assign load_v    = valid_i && (op_i == 2'd2);
  assign open_end  = addr_i + AW'(size_i);
  assign ext_sum   = {1'b0, run_end_q} + RunW'(size_i);
  // An open run whose end already overflowed the address space reads as end < start.
  assign wrapped   = run_end_q < run_start_q;
  assign ext_wrap  = ext_sum[AW] || wrapped;
  assign commit_ok = (run_len_q > MinRun) && !wrapped;

  always_comb begin
    state_d     = state_q;
    run_start_d = run_start_q;
    run_end_d   = run_end_q;
    run_len_d   = run_len_q;
    timer_d     = timer_q;
    commit      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (store_v) begin
          state_d     = StTrack;
          run_start_d = addr_i;
          run_end_d   = open_end;
          run_len_d   = RunW'(size_i);
          timer_d     = TimerInit;
        end
      end
      StTrack: begin
        if (store_v) begin
          if ((addr_i == run_end_q) && !ext_wrap) begin
            run_end_d = ext_sum[AW-1:0];
            run_len_d = run_len_q + RunW'(size_i);
            timer_d   = TimerInit;
          end else begin
            // Contiguous-but-wrapping stores drop the old run; others close it normally.
            commit      = (addr_i != run_end_q) && commit_ok;
            run_start_d = addr_i;
            run_end_d   = open_end;
            run_len_d   = RunW'(size_i);
            timer_d     = TimerInit;
          end
        end else if (timer_q == 8'd0) begin
          commit  = commit_ok;
          state_d = StIdle;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    match = (state_q == StTrack) && (addr_i >= run_start_q) && (addr_i < run_end_q);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_vld_q[PtrW'(i)] && (addr_i >= ent_start_q[PtrW'(i)]) &&
          (addr_i < ent_end_q[PtrW'(i)])) begin
        match = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      run_start_q <= '0;
      run_end_q   <= '0;
      run_len_q   <= '0;
      timer_q     <= '0;
      ent_vld_q   <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      hit_q       <= 1'b0;
    end else if (flush_i) begin
      state_q     <= StIdle;
      run_start_q <= '0;
      run_end_q   <= '0;
      run_len_q   <= '0;
      timer_q     <= '0;
      ent_vld_q   <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_start_q <= run_start_d;
      run_end_q   <= run_end_d;
      run_len_q   <= run_len_d;
      timer_q     <= timer_d;
      hit_q       <= load_v && match;
      if (commit) begin
        ent_vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q            <= wr_ptr_q + 1'b1;  // DEPTH is a power of two: wraps to 0
        if (count_q != CntMax) begin
          count_q <= count_q + 1'b1;
        end
      end
    end
  end

  // Entry payloads need no reset; the valid bits gate them.
  always_ff @(posedge clk_i) begin
    if (commit) begin
      ent_start_q[wr_ptr_q] <= run_start_q;
      ent_end_q[wr_ptr_q]   <= run_end_q;
    end
  end

`ifdef BOF_RANGE_CRASH_EN
  logic jump_v, armed_q, armed_d, crash_q, crash_d;

  assign jump_v = valid_i && (op_i == 2'd3);

  always_comb begin
    armed_d = armed_q;
    crash_d = 1'b0;
    if (load_v) begin
      armed_d = match;
    end else if (jump_v && armed_q) begin
      crash_d = 1'b1;
      armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      armed_q <= 1'b0;
      crash_q <= 1'b0;
    end else if (flush_i) begin
      armed_q <= 1'b0;
      crash_q <= 1'b0;
    end else begin
      armed_q <= armed_d;
      crash_q <= crash_d;
    end
  end

  assign crash_o = crash_q;
`else
  assign crash_o = 1'b0;
`endif

  assign hit_o    = hit_q;
  assign active_o = (state_q == StTrack);
  assign count_o  = count_q;

endmodule

// File: tb/tb_bof_range_monitor.sv
// Directed bench for bof_range_monitor: each operation queues its expected hit/crash result,
// which is popped and compared one cycle later; state outputs are checked directly.
module tb_bof_range_monitor;

  localparam int unsigned DEPTH = 8;
`ifdef BOF_RANGE_CRASH_EN
  localparam bit CrashEn = 1'b1;
`else
  localparam bit CrashEn = 1'b0;
`endif

  logic        clk_i, rst_ni, flush_i, valid_i, frame_i;
  logic [1:0]  op_i;
  logic [31:0] addr_i;
  logic [2:0]  size_i;
  logic        hit_o, crash_o, active_o;
  logic [$clog2(DEPTH):0] count_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string tag;
    logic  hit;
    logic  crash;
  } exp_t;

  exp_t sb[$];

  bof_range_monitor #(
    .DEPTH  (DEPTH),
    .AW     (32),
    .MIN_RUN(32),
    .TIMEOUT(10)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .op_i    (op_i),
    .addr_i  (addr_i),
    .size_i  (size_i),
    .frame_i (frame_i),
    .hit_o   (hit_o),
    .crash_o (crash_o),
    .active_o(active_o),
    .count_o (count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic op(input logic [1:0] o, input logic [31:0] a, input logic fr, input string tag,
                    input logic eh, input logic ec);
    exp_t e;
    e.tag = tag;
    e.hit = eh;
    e.crash = ec;
    valid_i = 1'b1;
    op_i    = o;
    addr_i  = a;
    size_i  = 3'd4;
    frame_i = fr;
    sb.push_back(e);
    step();
    valid_i = 1'b0;
    op_i    = 2'd0;
    frame_i = 1'b0;
    e = sb.pop_front();
    chk({e.tag, "/hit"}, 32'(hit_o), 32'(e.hit));
    chk({e.tag, "/crash"}, 32'(crash_o), 32'(e.crash));
  endtask

  task automatic sw(input logic [31:0] a);
    op(2'd1, a, 1'b0, "sw", 1'b0, 1'b0);
  endtask

  task automatic lw(input logic [31:0] a, input logic eh, input string tag);
    op(2'd2, a, 1'b0, tag, eh, 1'b0);
  endtask

  task automatic jmp(input logic ec, input string tag);
    op(2'd3, 32'h0, 1'b0, tag, 1'b0, ec);
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; op_i = 2'd0;
    addr_i = '0; size_i = 3'd0; frame_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_active", 32'(active_o), 0);
    chk("rst_count", 32'(count_o), 0);
    chk("rst_hit", 32'(hit_o), 0);
    chk("rst_crash", 32'(crash_o), 0);
    rst_ni = 1'b1;
    step();

    // Ten words from 0x1000 -> 40-byte run, committed on timeout
    for (int i = 0; i < 10; i++) sw(32'h1000 + 32'(4 * i));
    chk("run1_active", 32'(active_o), 1);
    idle(11);
    chk("run1_closed", 32'(active_o), 0);
    chk("run1_count", 32'(count_o), 1);
    lw(32'h1000, 1'b1, "run1_lo");
    lw(32'h1027, 1'b1, "run1_hi");
    lw(32'h1028, 1'b0, "run1_end");
    lw(32'h0fff, 1'b0, "run1_below");

    // Exactly MIN_RUN bytes: not committed
    for (int i = 0; i < 8; i++) sw(32'h2000 + 32'(4 * i));
    lw(32'h2004, 1'b1, "run2_open");
    idle(11);
    chk("run2_closed", 32'(active_o), 0);
    chk("run2_count", 32'(count_o), 1);
    lw(32'h2004, 1'b0, "run2_uncommitted");

    // Nine words with a frame store mixed in, closed by a non-contiguous store
    for (int i = 0; i < 4; i++) sw(32'h3000 + 32'(4 * i));
    op(2'd1, 32'h7000, 1'b1, "frame_sw", 1'b0, 1'b0);
    for (int i = 4; i < 9; i++) sw(32'h3000 + 32'(4 * i));
    sw(32'h5000);
    chk("run3_count", 32'(count_o), 2);
    chk("run3_active", 32'(active_o), 1);
    lw(32'h3000, 1'b1, "run3_lo");
    lw(32'h3023, 1'b1, "run3_hi");
    lw(32'h3024, 1'b0, "run3_end");
    lw(32'h5000, 1'b1, "open_5000");
    lw(32'h4ffc, 1'b0, "below_5000");
    lw(32'h7000, 1'b0, "frame_untracked");

    // Crash request: armed by a hit, disarmed by a miss
    lw(32'h1004, 1'b1, "arm_hit");
    jmp(CrashEn, "jmp_armed");
    idle(1);
    chk("crash_pulse_end", 32'(crash_o), 0);
    lw(32'h1004, 1'b1, "rearm_hit");
    lw(32'h9000, 1'b0, "disarm_miss");
    jmp(1'b0, "jmp_disarmed");

    // Run wrapping past the top of the address space is dropped
    for (int i = 0; i < 9; i++) sw(32'hffff_ffe0 + 32'(4 * i));
    chk("wrap_active", 32'(active_o), 1);
    lw(32'h0000_0000, 1'b1, "wrap_reopen");
    lw(32'hffff_fff0, 1'b0, "wrap_dropped");
    idle(12);
    chk("wrap_count", 32'(count_o), 2);
    lw(32'h0000_0000, 1'b0, "wrap_short");

    // Flush mid-run, with a load on the same edge
    for (int i = 0; i < 9; i++) sw(32'h6000 + 32'(4 * i));
    flush_i = 1'b1;
    lw(32'h1000, 1'b0, "flush_load");
    flush_i = 1'b0;
    chk("flush_active", 32'(active_o), 0);
    chk("flush_count", 32'(count_o), 0);
    idle(12);
    chk("flush_no_commit", 32'(count_o), 0);
    lw(32'h6000, 1'b0, "flush_run_gone");
    lw(32'h3000, 1'b0, "flush_entry_gone");

    // DEPTH+2 commits: the two oldest entries are overwritten
    for (int k = 0; k < DEPTH + 2; k++) begin
      for (int i = 0; i < 9; i++) sw(32'h10000 + 32'(k * 256 + 4 * i));
    end
    idle(12);
    chk("depth_count", 32'(count_o), DEPTH);
    lw(32'h10000, 1'b0, "evict0");
    lw(32'h10104, 1'b0, "evict1");
    lw(32'h10200, 1'b1, "keep2");
    lw(32'h10900, 1'b1, "last_lo");
    lw(32'h10923, 1'b1, "last_hi");
    lw(32'h10924, 1'b0, "last_end");

    // Asynchronous reset mid-run
    for (int i = 0; i < 9; i++) sw(32'h20000 + 32'(4 * i));
    lw(32'h20004, 1'b1, "pre_reset_hit");
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_active", 32'(active_o), 0);
    chk("arst_count", 32'(count_o), 0);
    chk("arst_hit", 32'(hit_o), 0);
    chk("arst_crash", 32'(crash_o), 0);
    #2 rst_ni = 1'b1;
    idle(12);
    chk("arst_no_commit", 32'(count_o), 0);
    lw(32'h20000, 1'b0, "arst_run_gone");
    lw(32'h10900, 1'b0, "arst_entry_gone");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
